// File: rtl/mem_access.sv
// mem_access: load/store unit between the CPU memory stage and a
// single-port word-wide data RAM without byte enables.
module mem_access #(
    parameter int ADDR_BITS = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_en,
    output logic        ram_we,
    output logic        ram_rst,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;

    logic        accept;
    logic        f3_bad;
    logic        range_bad;
    logic        align_bad;
    logic        req_bad;
    logic        is_sw;
    logic [31:0] merged;
    logic [31:0] load_ext;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign accept  = (state_q == S_IDLE) && req_valid;
    assign ram_rst = 1'b0;
    assign ram_addr = {addr_q[31:2], 2'b00};
    assign resp_err = err_q;
    assign is_sw = req_we && (req_funct3 == 3'b010);

    // Classify an incoming request as illegal, out of range or misaligned.
    always_comb begin
        f3_bad = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: f3_bad = 1'b1;
            3'b100, 3'b101:         f3_bad = req_we;
            default:                f3_bad = 1'b0;
        endcase
        range_bad = (req_addr >> ADDR_BITS) != 32'd0;
        align_bad = 1'b0;
        case (req_funct3[1:0])
            2'b01:   align_bad = req_addr[0];
            2'b10:   align_bad = (req_addr[1:0] != 2'b00);
            default: align_bad = 1'b0;
        endcase
        req_bad = f3_bad || range_bad || align_bad;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_d = S_RESP;
                    end else if (is_sw) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = we_q ? S_MERGE : S_RESP;
            S_MERGE: state_d = S_RESP;
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request fields and the error flag on accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_bad;
        end
    end

    // Lane insertion for sub-word stores and lane extraction for loads.
    always_comb begin
        merged = ram_dout;
        if (f3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
        lane_b = ram_dout[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = ram_dout;
        endcase
    end

    // Handshake and RAM controls decoded from the current state.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_di     = 32'd0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_READ: ram_en = 1'b1;
            S_MERGE: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
                ram_di = merged;
            end
            S_WRITE: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
                ram_di = wdata_q;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (!we_q && !err_q) begin
                    resp_rdata = load_ext;
                end
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule
